compressor_4_2_acc_pipe: RTL
============================

# compressor_4_2_acc_pipe

Parametrised W-bit row of true 4:2 compressors, with the horizontal carry chained between bit slices, followed by one registered output stage with valid/ready handshake. The block reduces four partial-product rows to a carry-save pair (sum, carry). An optional accumulate mode feeds the registered carry-save pair back in place of operands c/d. It sits in the Booth multiplier partial-product reduction path and in multi-cycle multiply-accumulate datapaths.

## Interface
- W, 8: operand width in bits.
- ACC_W, W+4: result width. Must be ≥ W+2. All arithmetic is modulo 2^ACC_W.
- SIGNED, 0: 1 means operands are two's-complement and are sign-extended to ACC_W. 0 means they are zero-extended.
- CNT_W, 4: width of the beat counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- in_acc  in  1  0 = fresh beat (a+b+c+d); 1 = accumulate (a+b+acc_sum+acc_carry).
- a, b, c, d  in  W each  operands. c and d are ignored when in_acc=1.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream consumes the result.
- sum_o  out  ACC_W  carry-save sum vector.
- carry_o  out  ACC_W  carry-save carry vector, already aligned (carry_o[0] is always 0).
- beat_cnt  out  CNT_W  number of beats folded into the current result.

## Operation
- Extension: each operand is extended to ACC_W (sign or zero, per SIGNED). acc_sum/acc_carry are the current sum_o/carry_o registers.
- Operand selection:
  - x0=a, x1=b always.
  - in_acc=0: x2=c, x3=d.
  - in_acc=1: x2=sum_o, x3=carry_o.
- Bit slice i, 0..ACC_W-1:
  - 3:2 on (x0[i], x1[i], x2[i]) gives s_i and co_i.
  - 3:2 on (s_i, x3[i], ci_i) gives d_i and c_i.
  - ci_0=0; ci_i=co_(i-1).
  - Next sum_o[i]=d_i; next carry_o[i+1]=c_i; next carry_o[0]=0.
  - co and c out of the top bit are discarded.
- Invariant: (sum_o+carry_o) mod 2^ACC_W equals the selected operand total mod 2^ACC_W.
- Accept: a beat is accepted when in_valid && in_ready. On accept, sum_o, carry_o and beat_cnt load and out_valid←1.
- beat_cnt on accept:
  - fresh beat: beat_cnt←1.
  - accumulate beat: beat_cnt←beat_cnt+1, saturating at 2^CNT_W−1.
- Consume: out_ready && out_valid with no accept in the same cycle sets out_valid←0.
- Result registers are not cleared on consume. They remain the accumulator for later in_acc beats.
- Accumulate when nothing has been produced since reset: the registers are 0, so the result is a+b and beat_cnt becomes 1.
- Implicit two-state control:
  - EMPTY (out_valid=0) to FULL on accept.
  - FULL to EMPTY on consume without accept.
  - FULL to FULL on accept with simultaneous consume.
- No combinational path from in_valid to out_valid. The only input-to-output combinational path is out_ready to in_ready.

## Timing
- Reset (asynchronous, rst_n=0): sum_o=0, carry_o=0, beat_cnt=0, out_valid=0. in_ready=1 once reset is released.
- in_ready = !out_valid || out_ready.
- Latency: a beat accepted at edge N is visible on sum_o/carry_o/out_valid immediately after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle while out_ready=1.
- Back-to-back accumulate beats: each beat uses the register value produced by the immediately preceding accept. This holds even when that result is being consumed in the same cycle.
- Backpressure (out_valid=1, out_ready=0):
  - in_ready=0.
  - All outputs hold stable.
  - in_valid and the operands may change without effect.
- Reset asserted mid-accumulation: state clears at once. The next in_acc beat starts from 0.
- Wrap-around: overflow beyond ACC_W bits wraps silently. There is no flag.

## Test plan
- Fresh beat, W=8, ACC_W=12, SIGNED=0, a=b=c=d=0xFF -> one cycle later out_valid=1, (sum_o+carry_o) mod 4096 = 0x3FC, carry_o[0]=0, beat_cnt=1.
- SIGNED=1, a=b=c=d=0x80 -> (sum_o+carry_o) mod 4096 = 0xE00 (−512).
- Fresh beat 1,2,3,4, then accumulate beat a=5,b=6 on the next cycle with out_ready=1 throughout -> totals 0x00A then 0x015; beat_cnt 1 then 2.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 and a result held -> in_ready=0, outputs stable, no beat lost. On release, pending beats are accepted in order, one per cycle.
- Wrap: fresh beat 0xFF×4 (=1020), then 7 accumulate beats a=b=0xFF (+510 each) -> final total 0x1EE (4590 mod 4096), beat_cnt=8. With CNT_W=3 the same sequence saturates beat_cnt at 7.
- Assert rst_n=0 asynchronously between accumulate beats -> outputs 0 immediately. After release, an accumulate beat a=1,b=1 gives total 2 and beat_cnt=1.

Source files
------------

// File: rtl/compressor_4_2_acc_pipe.sv
// Row of 4:2 compressors reducing four operands (or two operands plus the
// registered carry-save pair) to a carry-save result held in one output stage.
module compressor_4_2_acc_pipe #(
    parameter int W      = 8,
    parameter int ACC_W  = W + 4,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_acc,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum_o,
    output logic [ACC_W-1:0] carry_o,
    output logic [CNT_W-1:0] beat_cnt
);

    // Handshake: a beat transfers on in_valid && in_ready; a result transfers
    // on out_valid && out_ready. in_ready depends only on out_valid and out_ready.
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             accept;
    logic [ACC_W-1:0] x0, x1, x2, x3;
    logic [ACC_W-1:0] s_vec, co_vec, ci_vec, d_vec, c_vec;

    function automatic logic [ACC_W-1:0] ext(input logic [W-1:0] v);
        if (SIGNED != 0) begin
            ext = {{(ACC_W - W){v[W-1]}}, v};
        end else begin
            ext = {{(ACC_W - W){1'b0}}, v};
        end
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Compressor row: first 3:2 level feeds its carry one slice left into the second.
    always_comb begin
        x0     = ext(a);
        x1     = ext(b);
        x2     = in_acc ? sum_q   : ext(c);
        x3     = in_acc ? carry_q : ext(d);
        s_vec  = x0 ^ x1 ^ x2;
        co_vec = (x0 & x1) | (x0 & x2) | (x1 & x2);
        ci_vec = {co_vec[ACC_W-2:0], 1'b0};
        d_vec  = s_vec ^ x3 ^ ci_vec;
        c_vec  = (s_vec & x3) | (s_vec & ci_vec) | (x3 & ci_vec);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        beat_cnt_d  = beat_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            sum_d       = d_vec;
            carry_d     = {c_vec[ACC_W-2:0], 1'b0};
            if (!in_acc) begin
                beat_cnt_d = CNT_W'(1);
            end else if (beat_cnt_q != {CNT_W{1'b1}}) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            beat_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum_o     = sum_q;
    assign carry_o   = carry_q;
    assign beat_cnt  = beat_cnt_q;

endmodule
